// File: rtl/fmul_exp_pkg.sv
// Shared floating-point helpers for the multiplier exponent path.
// Holds the bias / saturation derivations and the encoding of the two
// guard bits above the exponent field of the exponent sum.
package fmul_exp_pkg;

  // Guard-bit patterns of the SUM_W-bit exponent sum.
  typedef enum logic [1:0] {
    TOP_NORM = 2'b00,  // in range (or exactly all-ones -> infinity)
    TOP_OVF  = 2'b01,  // beyond the largest encodable exponent
    TOP_BAD  = 2'b10,  // cannot arise from two biased exponents
    TOP_NEG  = 2'b11   // negative sum -> denormal result
  } sum_top_e;

  // IEEE-style exponent bias: 2^(exp_w-1) - 1.
  function automatic int unsigned bias_of(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Largest meaningful denormal shift: hidden bit plus stored mantissa plus one.
  function automatic int unsigned sat_of(input int unsigned man_w);
    return man_w + 32'd2;
  endfunction

endpackage

// File: rtl/fmul_exp_class.sv
// Combinational classification of the biased exponent sum.
// Ports:
//   sum          SUM_W-bit two's-complement exponent sum (SUM_W = EXP_W+2)
//   exp_res      result exponent field
//   denorm_shift mantissa right-shift for denormal results (saturated at SAT)
//   is_inf, is_ovf, is_uflow  mutually exclusive class flags
module fmul_exp_class
  import fmul_exp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic signed [EXP_W+1:0] sum,
  output logic [EXP_W-1:0]        exp_res,
  output logic [EXP_W-1:0]        denorm_shift,
  output logic                    is_inf,
  output logic                    is_ovf,
  output logic                    is_uflow
);

  localparam int SUM_W = EXP_W + 2;
  localparam int SAT   = int'(sat_of(MAN_W));

  // Returns {uflow, shift}: shifts past SAT-1 would flush the whole mantissa,
  // so they are clamped to SAT and reported as underflow.
  function automatic logic [EXP_W:0] sat_shift(input logic [SUM_W-1:0] mag);
    if (mag > SUM_W'(SAT - 1))
      return {1'b1, EXP_W'(SAT)};
    else
      return {1'b0, mag[EXP_W-1:0]};
  endfunction

  sum_top_e         top;
  logic [SUM_W-1:0] mag;

  always_comb begin
    top          = sum_top_e'(sum[SUM_W-1:SUM_W-2]);
    mag          = '0;
    exp_res      = sum[EXP_W-1:0];
    denorm_shift = '0;
    is_inf       = 1'b0;
    is_ovf       = 1'b0;
    is_uflow     = 1'b0;
    if (top == TOP_NEG || sum == '0) begin
      // A zero sum still needs one shift to expose the hidden bit.
      mag = (sum == '0) ? SUM_W'(1) : SUM_W'(1) - $unsigned(sum);
      {is_uflow, denorm_shift} = sat_shift(mag);
      exp_res = '0;
    end else if (top == TOP_OVF) begin
      is_ovf  = 1'b1;
      exp_res = '1;
    end else if (top == TOP_NORM && (&sum[EXP_W-1:0])) begin
      is_inf  = 1'b1;
      exp_res = '1;
    end
  end

endmodule

// File: rtl/fmul_exp_pipe.sv
// Two-stage exponent pipeline of a floating-point multiplier.
// Stage 1 registers the biased exponent sum, stage 2 registers its
// classification; both stages use a valid/ready handshake with no bubbles.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand handshake; exp_a, exp_b, man_carry
//   out_valid/out_ready      result handshake; exp_res, denorm_shift,
//                            is_inf, is_ovf, is_uflow
//   flag_clr                 clears sticky flags and event counters
//   sticky_ovf, sticky_uflow sticky event flags
//   ovf_cnt, uflow_cnt       saturating event counters
module fmul_exp_pipe
  import fmul_exp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             man_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_res,
  output logic [EXP_W-1:0] denorm_shift,
  output logic             is_inf,
  output logic             is_ovf,
  output logic             is_uflow,
  input  logic             flag_clr,
  output logic             sticky_ovf,
  output logic             sticky_uflow,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] uflow_cnt
);

  localparam int SUM_W = EXP_W + 2;
  localparam int BIAS  = int'(bias_of(EXP_W));
  localparam logic signed [SUM_W-1:0] BIAS_S = SUM_W'(BIAS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic                    vld_p1, vld_p2;
  logic                    adv_p2, in_hs, out_hs, ovf_ev, uflow_ev;
  logic signed [SUM_W-1:0] sum_p0, sum_p1;
  logic [EXP_W-1:0]        cls_exp_res, cls_shift;
  logic                    cls_inf, cls_ovf, cls_uflow;

  // Stage 2 can load whenever it is empty or its result leaves this cycle,
  // which lets a full pipe drain and refill without a bubble.
  assign adv_p2    = ~vld_p2 | out_ready;
  assign in_ready  = ~rst & (~vld_p1 | adv_p2);
  assign in_hs     = in_valid & in_ready;
  assign out_valid = vld_p2;
  assign out_hs    = vld_p2 & out_ready;
  assign ovf_ev    = out_hs & (is_ovf | is_inf);
  assign uflow_ev  = out_hs & is_uflow;

  assign sum_p0 = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S
                + $signed({{(SUM_W-1){1'b0}}, man_carry});

  // ---- stage 1: exponent sum ----
  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (in_ready)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_hs)
      sum_p1 <= sum_p0;
  end

  // ---- stage 2: classification ----
  fmul_exp_class #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_class (
    .sum         (sum_p1),
    .exp_res     (cls_exp_res),
    .denorm_shift(cls_shift),
    .is_inf      (cls_inf),
    .is_ovf      (cls_ovf),
    .is_uflow    (cls_uflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2       <= 1'b0;
      exp_res      <= '0;
      denorm_shift <= '0;
      is_inf       <= 1'b0;
      is_ovf       <= 1'b0;
      is_uflow     <= 1'b0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        exp_res      <= cls_exp_res;
        denorm_shift <= cls_shift;
        is_inf       <= cls_inf;
        is_ovf       <= cls_ovf;
        is_uflow     <= cls_uflow;
      end
    end
  end

  // ---- event tracking on output handshake ----
  // A set coinciding with flag_clr wins and restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf   <= 1'b0;
      sticky_uflow <= 1'b0;
      ovf_cnt      <= '0;
      uflow_cnt    <= '0;
    end else begin
      if (ovf_ev) begin
        sticky_ovf <= 1'b1;
        ovf_cnt    <= flag_clr ? CNT_W'(1) : sat_inc(ovf_cnt);
      end else if (flag_clr) begin
        sticky_ovf <= 1'b0;
        ovf_cnt    <= '0;
      end
      if (uflow_ev) begin
        sticky_uflow <= 1'b1;
        uflow_cnt    <= flag_clr ? CNT_W'(1) : sat_inc(uflow_cnt);
      end else if (flag_clr) begin
        sticky_uflow <= 1'b0;
        uflow_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fmul_exp_pipe.sv
module tb_fmul_exp_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] exp_a = '0, exp_b = '0;
  logic       man_carry = 1'b0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] exp_res, denorm_shift;
  logic       is_inf, is_ovf, is_uflow;
  logic       flag_clr = 1'b0;
  logic       sticky_ovf, sticky_uflow;
  logic [3:0] ovf_cnt, uflow_cnt;

  fmul_exp_pipe #(.EXP_W(8), .MAN_W(23), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .man_carry(man_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_res(exp_res), .denorm_shift(denorm_shift),
    .is_inf(is_inf), .is_ovf(is_ovf), .is_uflow(is_uflow),
    .flag_clr(flag_clr), .sticky_ovf(sticky_ovf), .sticky_uflow(sticky_uflow),
    .ovf_cnt(ovf_cnt), .uflow_cnt(uflow_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: results expected in order, plus sticky/counter model.
  logic [18:0] expq[$];
  logic        m_sov, m_suf;
  int          m_ocnt, m_ucnt;

  // Per-cycle observations written by step().
  logic        s_in_rdy, s_in_hs, s_out_vld, s_out_hs;
  logic [18:0] s_obs, s_exp;
  logic [9:0]  s_st, s_st_exp;

  // Result packed as {exp_res, denorm_shift, is_inf, is_ovf, is_uflow},
  // derived from the arithmetic value of the exponent sum.
  function automatic logic [18:0] model(int a, int b, int c);
    int s, sh;
    s = a + b - 127 + c;
    if (s <= 0) begin
      sh = 1 - s;
      if (sh > 24) return {8'd0, 8'd25, 3'b001};
      return {8'd0, 8'(sh), 3'b000};
    end
    if (s == 255) return {8'hff, 8'd0, 3'b100};
    if (s > 255)  return {8'hff, 8'd0, 3'b010};
    return {8'(s), 8'd0, 3'b000};
  endfunction

  function automatic int sat15(int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  task automatic step(input logic v, input int a, input int b, input logic c,
                      input logic ordy, input logic clr);
    @(negedge clk);
    in_valid = v; exp_a = 8'(a); exp_b = 8'(b); man_carry = c;
    out_ready = ordy; flag_clr = clr;
    #1;
    s_in_rdy  = in_ready;
    s_out_vld = out_valid;
    s_in_hs   = v & in_ready;
    s_out_hs  = out_valid & ordy;
    s_obs     = {exp_res, denorm_shift, is_inf, is_ovf, is_uflow};
    s_st      = {sticky_ovf, sticky_uflow, ovf_cnt, uflow_cnt};
    s_st_exp  = {m_sov, m_suf, 4'(m_ocnt), 4'(m_ucnt)};
    s_exp     = 'x;
    if (s_out_hs && expq.size() > 0) s_exp = expq.pop_front();
    if (s_in_hs) expq.push_back(model(a, b, int'(c)));
    if (clr) begin m_sov = 0; m_suf = 0; m_ocnt = 0; m_ucnt = 0; end
    if (s_out_hs && !$isunknown(s_exp)) begin
      if (s_exp[2] | s_exp[1]) begin m_sov = 1; m_ocnt = sat15(m_ocnt); end
      if (s_exp[0])            begin m_suf = 1; m_ucnt = sat15(m_ucnt); end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; flag_clr = 0; out_ready = 0;
    @(negedge clk);
    rst = 0;
    expq.delete();
    m_sov = 0; m_suf = 0; m_ocnt = 0; m_ucnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; in_valid = 1; exp_a = 8'd254; exp_b = 8'd254; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, exp_res, denorm_shift, is_inf, is_ovf, is_uflow} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b res=%h sh=%h f=%b%b%b expected all 0",
               out_valid, exp_res, denorm_shift, is_inf, is_ovf, is_uflow);
    end
    checks++;
    if ({sticky_ovf, sticky_uflow, ovf_cnt, uflow_cnt} !== 10'd0) begin
      errors++; $display("FAIL reset_counters: got %h expected 0",
                         {sticky_ovf, sticky_uflow, ovf_cnt, uflow_cnt});
    end
    @(negedge clk);
    rst = 0; in_valid = 0;
    expq.delete();
    m_sov = 0; m_suf = 0; m_ocnt = 0; m_ucnt = 0;
  endtask

  task automatic test_normal();
    do_reset();
    step(1, 127, 127, 0, 1, 0);
    checks++;
    if (s_in_rdy !== 1'b1) begin
      errors++; $display("FAIL normal_in_ready: got %b expected 1", s_in_rdy);
    end
    step(0, 0, 0, 0, 1, 0);
    checks++;
    if (s_out_vld !== 1'b0) begin
      errors++; $display("FAIL normal_early_valid: got %b expected 0", s_out_vld);
    end
    step(0, 0, 0, 0, 1, 0);
    checks++;
    if (s_out_hs !== 1'b1 || s_obs !== {8'd127, 8'd0, 3'b000}) begin
      errors++; $display("FAIL normal_result: got hs=%b %h expected hs=1 %h",
                         s_out_hs, s_obs, {8'd127, 8'd0, 3'b000});
    end
  endtask

  task automatic test_inf_ovf();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      step(1, 200, 182, 0, 1, 0);
      else if (i == 1) step(1, 254, 254, 0, 1, 0);
      else             step(0, 0, 0, 0, 1, 0);
      if (s_out_hs) begin
        checks++;
        if (s_obs !== s_exp) begin
          errors++; $display("FAIL inf_ovf_result: got %h expected %h", s_obs, s_exp);
        end
        checks++;
        if (s_obs[18:11] !== 8'hff) begin
          errors++; $display("FAIL inf_ovf_exp: got %h expected ff", s_obs[18:11]);
        end
      end
      checks++;
      if (s_st !== s_st_exp) begin
        errors++; $display("FAIL inf_ovf_flags: got %h expected %h", s_st, s_st_exp);
      end
    end
    checks++;
    if (sticky_ovf !== 1'b1 || ovf_cnt !== 4'd2) begin
      errors++; $display("FAIL inf_ovf_count: got sticky=%b cnt=%0d expected sticky=1 cnt=2",
                         sticky_ovf, ovf_cnt);
    end
  endtask

  task automatic test_denorm();
    int ta[7] = '{27, 20, 1, 4, 3, 26, 127};
    int tb[7] = '{100, 100, 100, 100, 100, 100, 1};
    int tc[7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [18:0] got[$];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 7) step(1, ta[i], tb[i], tc[i], 1, 0);
      else       step(0, 0, 0, 0, 1, 0);
      if (s_out_hs) begin
        got.push_back(s_obs);
        checks++;
        if (s_obs !== s_exp) begin
          errors++; $display("FAIL denorm_result: got %h expected %h", s_obs, s_exp);
        end
      end
      checks++;
      if (s_st !== s_st_exp) begin
        errors++; $display("FAIL denorm_flags: got %h expected %h", s_st, s_st_exp);
      end
    end
    checks++;
    if (got.size() != 7) begin
      errors++; $display("FAIL denorm_count: got %0d results expected 7", got.size());
    end else begin
      checks++;
      if (got[0] !== {8'd0, 8'd1, 3'b000} || got[1] !== {8'd0, 8'd8, 3'b000} ||
          got[2] !== {8'd0, 8'd25, 3'b001}) begin
        errors++; $display("FAIL denorm_shift: got %h %h %h expected 00008 00040 000c9",
                           got[0], got[1], got[2]);
      end
      checks++;
      if (got[3] !== {8'd0, 8'd24, 3'b000} || got[4] !== {8'd0, 8'd25, 3'b001}) begin
        errors++; $display("FAIL denorm_sat_edge: got %h %h expected 000c0 000c9",
                           got[3], got[4]);
      end
    end
    checks++;
    if (sticky_uflow !== 1'b1 || uflow_cnt !== 4'd2) begin
      errors++; $display("FAIL denorm_uflow_cnt: got sticky=%b cnt=%0d expected 1 2",
                         sticky_uflow, uflow_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n_out = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(1, $urandom_range(0, 255), $urandom_range(0, 255),
                      1'($urandom_range(0, 1)), 1, 0);
      else       step(0, 0, 0, 0, 1, 0);
      if (i < 8) begin
        checks++;
        if (s_in_rdy !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", i, s_in_rdy);
        end
      end
      checks++;
      if (s_out_vld !== (i >= 2)) begin
        errors++; $display("FAIL b2b_out_valid: cycle %0d got %b expected %b",
                           i, s_out_vld, i >= 2);
      end
      if (s_out_hs) begin
        n_out++;
        checks++;
        if (s_obs !== s_exp) begin
          errors++; $display("FAIL b2b_result: got %h expected %h", s_obs, s_exp);
        end
      end
    end
    checks++;
    if (n_out != 8) begin
      errors++; $display("FAIL b2b_count: got %0d expected 8", n_out);
    end
  endtask

  task automatic test_backpressure();
    int pa[4] = '{127, 200, 254, 20};
    int pb[4] = '{130, 182, 254, 100};
    int idx = 0, n_out = 0, occ;
    logic        ordy, hold;
    logic [18:0] prev;
    hold = 0; prev = '0;
    do_reset();
    for (int cy = 0; cy < 14; cy++) begin
      ordy = !(cy >= 2 && cy <= 4);
      occ  = expq.size();
      if (idx < 4) step(1, pa[idx], pb[idx], 0, ordy, 0);
      else         step(0, 0, 0, 0, ordy, 0);
      if (s_in_hs) idx++;
      checks++;
      if (s_in_rdy !== !(occ == 2 && !ordy)) begin
        errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b",
                           cy, s_in_rdy, !(occ == 2 && !ordy));
      end
      if (hold) begin
        checks++;
        if (s_out_vld !== 1'b1 || s_obs !== prev) begin
          errors++; $display("FAIL bp_hold: cycle %0d got v=%b %h expected v=1 %h",
                             cy, s_out_vld, s_obs, prev);
        end
      end
      if (s_out_hs) begin
        n_out++;
        checks++;
        if (s_obs !== s_exp) begin
          errors++; $display("FAIL bp_result: got %h expected %h", s_obs, s_exp);
        end
      end
      hold = s_out_vld & ~ordy;
      prev = s_obs;
    end
    checks++;
    if (n_out != 4 || idx != 4) begin
      errors++; $display("FAIL bp_count: got %0d out %0d in expected 4 4", n_out, idx);
    end
  endtask

  task automatic test_flag_clr();
    do_reset();
    for (int cy = 0; cy < 8; cy++) begin
      step(cy < 3, 254, 254, 0, 1, (cy == 4) || (cy == 6));
      if (s_out_hs) begin
        checks++;
        if (s_obs !== s_exp) begin
          errors++; $display("FAIL clr_result: got %h expected %h", s_obs, s_exp);
        end
      end
      checks++;
      if (s_st !== s_st_exp) begin
        errors++; $display("FAIL clr_flags: cycle %0d got %h expected %h", cy, s_st, s_st_exp);
      end
      if (cy == 5) begin
        checks++;
        if (s_st[9] !== 1'b1 || s_st[7:4] !== 4'd1) begin
          errors++; $display("FAIL clr_set_wins: got sticky=%b cnt=%0d expected 1 1",
                             s_st[9], s_st[7:4]);
        end
      end
      if (cy == 7) begin
        checks++;
        if (s_st[9] !== 1'b0 || s_st[7:4] !== 4'd0) begin
          errors++; $display("FAIL clr_clears: got sticky=%b cnt=%0d expected 0 0",
                             s_st[9], s_st[7:4]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 44; i++) begin
      if (i < 40) begin
        if (i % 2 == 0) step(1, 254, 254, 0, 1, 0);
        else            step(1, 1, 1, 0, 1, 0);
      end else step(0, 0, 0, 0, 1, 0);
      checks++;
      if (s_st !== s_st_exp) begin
        errors++; $display("FAIL sat_flags: step %0d got %h expected %h", i, s_st, s_st_exp);
      end
    end
    checks++;
    if (ovf_cnt !== 4'hf || uflow_cnt !== 4'hf) begin
      errors++; $display("FAIL sat_counters: got %0d %0d expected 15 15", ovf_cnt, uflow_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 420; i++) begin
      if (i < 400)
        step($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      else
        step(0, 0, 0, 0, 1, 0);
      if (s_out_hs) begin
        checks++;
        if (s_obs !== s_exp) begin
          errors++; $display("FAIL rand_result: step %0d got %h expected %h", i, s_obs, s_exp);
        end
      end
      checks++;
      if (s_st !== s_st_exp) begin
        errors++; $display("FAIL rand_flags: step %0d got %h expected %h", i, s_st, s_st_exp);
      end
    end
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL rand_drain: got %0d pending expected 0", expq.size());
    end
  endtask

  task automatic test_rst_midflight();
    do_reset();
    step(1, 254, 254, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    checks++;
    if (ovf_cnt !== 4'd1) begin
      errors++; $display("FAIL midrst_pre: got cnt=%0d expected 1", ovf_cnt);
    end
    step(1, 254, 254, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    rst = 0;
    expq.delete();
    m_sov = 0; m_suf = 0; m_ocnt = 0; m_ucnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1, 0);
      checks++;
      if (s_out_vld !== 1'b0) begin
        errors++; $display("FAIL midrst_valid: cycle %0d got %b expected 0", i, s_out_vld);
      end
      checks++;
      if (s_st !== 10'd0) begin
        errors++; $display("FAIL midrst_counters: cycle %0d got %h expected 0", i, s_st);
      end
    end
  endtask

  initial begin
    m_sov = 0; m_suf = 0; m_ocnt = 0; m_ucnt = 0;
    test_reset();
    test_normal();
    test_inf_ovf();
    test_denorm();
    test_back_to_back();
    test_backpressure();
    test_flag_clr();
    test_saturation();
    test_random();
    test_rst_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmul_exp_pipe.md
FMUL_EXP_PIPE -- requirements
Module: fmul_exp_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8: exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23: stored mantissa width.
REQ-003 SHALL have parameter CNT_W, default 16: event counter width.
REQ-004 SHALL derive localparams BIAS = 2^(EXP_W-1)-1, SUM_W = EXP_W+2, SAT = MAN_W+2.
REQ-005 SHALL have one clock and synchronous active-high reset. Ports: clk, in, 1, clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operand pair valid.
REQ-008 in_ready  out  1  stage accepts operands.
REQ-009 exp_a, exp_b  in  EXP_W each  biased operand exponents.
REQ-010 man_carry  in  1  mantissa product normalisation carry (+1 to exponent).
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 exp_res  out  EXP_W  result exponent field.
REQ-014 denorm_shift  out  EXP_W  mantissa right-shift for denormal result.
REQ-015 is_inf, is_ovf, is_uflow  out  1 each  result class flags.
REQ-016 flag_clr  in  1  clears sticky flags.
REQ-017 sticky_ovf, sticky_uflow  out  1 each  sticky event flags.
REQ-018 ovf_cnt, uflow_cnt  out  CNT_W each  saturating event counters.

Function
REQ-019 Stage 1 SHALL register sum = exp_a + exp_b - BIAS + man_carry, computed in SUM_W-bit two's complement.
REQ-020 Stage 2 SHALL register the classification of sum and drive all result outputs from registers.
REQ-021 Latency SHALL be 2 cycles from input handshake to out_valid with out_ready high, at a throughput of 1 result per cycle.
REQ-022 Handshake SHALL be valid/ready: a transfer occurs when valid & ready; out_valid and result outputs SHALL stay stable while out_valid & ~out_ready.
REQ-023 in_ready SHALL equal ~v1 | ~v2 | out_ready, where v1/v2 are the stage valids; no bubble SHALL be inserted when a full pipe drains and fills in the same cycle.
REQ-024 Denormal condition: sum[SUM_W-1:SUM_W-2] == 2'b11, or sum == 0.
REQ-025 If denormal and sum == 0: denorm_shift = 1.
REQ-026 If denormal and sum != 0: denorm_shift = 1 - sum (two's complement).
REQ-027 If the denormal shift exceeds SAT-1: is_uflow = 1 and denorm_shift = SAT.
REQ-028 For any denormal result, exp_res SHALL be 0.
REQ-029 is_inf = 1 when sum[SUM_W-1:SUM_W-2] == 2'b00 and sum[EXP_W-1:0] is all ones.
REQ-030 is_ovf = 1 when sum[SUM_W-1:SUM_W-2] == 2'b01.
REQ-031 When is_inf or is_ovf is set, exp_res SHALL be all ones.
REQ-032 Normal results: exp_res = sum[EXP_W-1:0], denorm_shift = 0, all flags 0.
REQ-033 At most one of is_inf, is_ovf, is_uflow SHALL be 1 at a time.
REQ-034 On each output handshake: is_ovf | is_inf sets sticky_ovf and increments ovf_cnt; is_uflow sets sticky_uflow and increments uflow_cnt.
REQ-035 Counters SHALL saturate at all ones and never wrap.
REQ-036 flag_clr SHALL clear sticky flags and counters next cycle; when clear and set coincide, the set SHALL win (flag = 1, counter = 1).

Reset
REQ-037 While rst is high: in_ready, out_valid and stage valids SHALL be 0; inputs SHALL be ignored.
REQ-038 Reset SHALL zero exp_res, denorm_shift, all class flags, sticky flags and counters.
REQ-039 Reset asserted mid-operation SHALL discard in-flight results with no output handshake produced.

Structure
REQ-040 The shared FP package SHALL hold the BIAS/SAT derivation functions and the class encoding constants.
REQ-041 Classification SHALL be a combinational sub-module fmul_exp_class (parameter EXP_W, MAN_W), instantiated in stage 2.

Verification (EXP_W=8, MAN_W=23)
REQ-042 Normal: a=127, b=127, c=0 -> after 2 cycles exp_res=127, shift=0, flags 0.
REQ-043 Infinity and overflow: a=200, b=182 -> exp_res=255, is_inf=1. Then a=254, b=254 -> is_ovf=1, sticky_ovf=1, ovf_cnt=2.
REQ-044 Denormal: a=27, b=100 -> shift=1. Then a=20, b=100 -> shift=8. Then a=1, b=100 -> is_uflow=1, shift=25. exp_res=0 for all three.
REQ-045 Backpressure: stream 4 pairs with out_ready low for 3 cycles -> in_ready drops only when both stages are full; outputs hold and all 4 results arrive in order without loss.
REQ-046 flag_clr asserted in the same cycle as an overflow handshake -> sticky_ovf=1 and ovf_cnt=1.
REQ-047 rst pulsed with 2 results in flight -> no out_valid afterwards; counters=0.
